nios_custom_dma_cpu_div_cell: RTL

Iterative radix-2 restoring divider for the Nios II custom CPU datapath; the inverse-direction companion of the pipelined multiply cell.
- Accepts E-stage operands and produces the quotient for div/divu several cycles later.
- Signals completion with a done pulse; the pipeline stalls on busy.
- Shares the operand naming and clock/reset of the multiply path.

---
 rtl/nios_custom_dma_cpu_div_pkg.sv | 20 ++
 rtl/nios_custom_dma_cpu_div_step.sv | 23 ++
 rtl/nios_custom_dma_cpu_div_cell.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/nios_custom_dma_cpu_div_pkg.sv
// Shared types and helpers for the Nios II iterative divide cell.
package nios_custom_dma_cpu_div_pkg;

    localparam int DIV_DATA_W = 32;
    localparam int DIV_MAX_W  = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } div_state_t;

    // Width-generic two's-complement negate; callers zero-extend in and truncate out.
    function automatic logic [DIV_MAX_W-1:0] twos_neg(input logic [DIV_MAX_W-1:0] v);
        return -v;
    endfunction

endpackage

// File: rtl/nios_custom_dma_cpu_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module nios_custom_dma_cpu_div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W:0]   rem_in,
    input  logic              dvd_bit,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W:0]   rem_out,
    output logic              q_bit
);

    logic [DATA_W:0] partial;
    logic [DATA_W:0] diff;

    always_comb begin
        partial = {rem_in[DATA_W-1:0], dvd_bit};
        diff    = partial - {1'b0, divisor};
        // rem_in stays below the divisor, so its top bit is zero; if set it could only mean "subtract".
        q_bit   = rem_in[DATA_W] | (partial >= {1'b0, divisor});
        rem_out = q_bit ? diff : partial;
    end

endmodule

// File: rtl/nios_custom_dma_cpu_div_cell.sv
// Iterative radix-2 restoring divider for div/divu; stalls the pipeline via busy.
// Optional remainder output enabled by defining CPU_DIV_REM_EN.
module nios_custom_dma_cpu_div_cell
    import nios_custom_dma_cpu_div_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              E_div_start,
    input  logic              E_div_signed,
    input  logic              E_div_kill,
    input  logic [DATA_W-1:0] E_src1,
    input  logic [DATA_W-1:0] E_src2,
    output logic              M_div_busy,
    output logic              M_div_done,
    output logic [DATA_W-1:0] M_div_quot
`ifdef CPU_DIV_REM_EN
    ,
    output logic [DATA_W-1:0] M_div_rem
`endif
);

    function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v);
        return DATA_W'(twos_neg(DIV_MAX_W'(v)));
    endfunction

    function automatic logic [DATA_W-1:0] abs_w(input logic [DATA_W-1:0] v, input logic sgn);
        return (sgn && v[DATA_W-1]) ? neg_w(v) : v;
    endfunction

    div_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] dvd;     // dividend shifts out MSB-first while quotient bits shift in
    logic [DATA_W-1:0] dsr;
    logic [DATA_W:0]   prem;
    logic              sgn;
    logic              q_neg;
    logic [DATA_W-1:0] quot_r;
    logic [DATA_W:0]   step_rem;
    logic              step_q;
    logic              start_ok;

    assign start_ok = E_div_start & ~E_div_kill;

    nios_custom_dma_cpu_div_step #(.DATA_W(DATA_W)) u_step (
        .rem_in  (prem),
        .dvd_bit (dvd[DATA_W-1]),
        .divisor (dsr),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state != S_IDLE && E_div_kill) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start_ok) state_nxt = S_PREP;
                S_PREP:  state_nxt = (dsr == '0) ? S_FIX : S_ITER;
                S_ITER:  if (cnt == CNT_W'(1)) state_nxt = S_FIX;
                S_FIX:   state_nxt = S_DONE;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

`ifdef CPU_DIV_REM_EN
    logic              r_neg;
    logic [DATA_W-1:0] rem_r;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_neg <= 1'b0;
            rem_r <= '0;
        end else if (state == S_PREP) begin
            // Remainder follows the dividend sign, so divide-by-zero returns the dividend unchanged.
            r_neg <= sgn & dvd[DATA_W-1];
        end else if (state == S_FIX && !E_div_kill) begin
            rem_r <= r_neg ? neg_w(prem[DATA_W-1:0]) : prem[DATA_W-1:0];
        end
    end

    assign M_div_rem = rem_r;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt    <= '0;
            dvd    <= '0;
            dsr    <= '0;
            prem   <= '0;
            sgn    <= 1'b0;
            q_neg  <= 1'b0;
            quot_r <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        dvd <= E_src1;
                        dsr <= E_src2;
                        sgn <= E_div_signed;
                    end
                end
                S_PREP: begin
                    dsr  <= abs_w(dsr, sgn);
                    cnt  <= CNT_W'(DATA_W);
                    if (dsr == '0) begin
                        dvd   <= '1;
                        prem  <= {1'b0, abs_w(dvd, sgn)};
                        q_neg <= 1'b0;
                    end else begin
                        dvd   <= abs_w(dvd, sgn);
                        prem  <= '0;
                        q_neg <= sgn & (dvd[DATA_W-1] ^ dsr[DATA_W-1]);
                    end
                end
                S_ITER: begin
                    prem <= step_rem;
                    dvd  <= {dvd[DATA_W-2:0], step_q};
                    cnt  <= cnt - CNT_W'(1);
                end
                S_FIX: begin
                    if (!E_div_kill) quot_r <= q_neg ? neg_w(dvd) : dvd;
                end
                default: ;
            endcase
        end
    end

    assign M_div_busy = (state == S_PREP) || (state == S_ITER) || (state == S_FIX);
    assign M_div_done = (state == S_DONE);
    assign M_div_quot = quot_r;

endmodule
